// File: rtl/watch_pkg.sv
// Shared constants for the watch timekeeping stages: field moduli, FSM states
// and adjust-select codes.
package watch_pkg;

  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ADJ = 1'b1
  } hms_state_t;

  localparam logic [1:0] ADJ_SEC  = 2'd0;
  localparam logic [1:0] ADJ_MIN  = 2'd1;
  localparam logic [1:0] ADJ_HOUR = 2'd2;
  localparam logic [1:0] ADJ_NONE = 2'd3;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with clear/load/increment priority.
// The wrap output flags an increment from MOD-1 this cycle.
module mod_counter #(
  parameter int WIDTH = 6,
  parameter int MOD   = 60
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

  assign wrap = inc && (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hms_counter.sv
// Hours:minutes:seconds time of day driven by the one-second tick, with clear,
// validated load and a frozen field-by-field adjust mode.
//
// state  | meaning
// ST_RUN | ticks advance the time, carries ripple sec->min->hour
// ST_ADJ | time frozen, i_adj_inc bumps the selected field only
module hms_counter
  import watch_pkg::*;
#(
  parameter int SEC_BIT  = 6,
  parameter int MIN_BIT  = 6,
  parameter int HOUR_BIT = 6,
  parameter int HOUR_MAX = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_sec_tick,
  input  logic                i_clear,
  input  logic                i_load,
  input  logic [SEC_BIT-1:0]  i_load_sec,
  input  logic [MIN_BIT-1:0]  i_load_min,
  input  logic [HOUR_BIT-1:0] i_load_hour,
  input  logic                i_adj_en,
  input  logic [1:0]          i_adj_sel,
  input  logic                i_adj_inc,
  output logic [SEC_BIT-1:0]  o_sec,
  output logic [MIN_BIT-1:0]  o_min,
  output logic [HOUR_BIT-1:0] o_hour,
  output logic                o_min_tick,
  output logic                o_hour_tick,
  output logic                o_day_tick,
  output logic                o_adj_mode,
  output logic                o_load_err
);

  hms_state_t state, state_nxt;

  logic run, busy, load_ok, load_acc, load_bad;
  logic adj_inc;
  logic sec_inc, min_inc, hour_inc;
  logic sec_wrap, min_wrap, hour_wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (i_adj_en)  state_nxt = ST_ADJ;
      ST_ADJ:  if (!i_adj_en) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  assign run      = (state == ST_RUN);
  assign busy     = i_clear || i_load;
  assign load_ok  = (32'(i_load_sec) < SEC_MOD) && (32'(i_load_min) < MIN_MOD) &&
                    (32'(i_load_hour) < HOUR_MAX);
  assign load_acc = i_load && !i_clear && load_ok;
  assign load_bad = i_load && !i_clear && !load_ok;
  assign adj_inc  = !run && !busy && i_adj_inc;

  // In adjust mode a field wrap must not carry, so carries are gated by run.
  assign sec_inc  = run ? (!busy && i_sec_tick) : (adj_inc && (i_adj_sel == ADJ_SEC));
  assign min_inc  = run ? sec_wrap : (adj_inc && (i_adj_sel == ADJ_MIN));
  assign hour_inc = run ? min_wrap : (adj_inc && (i_adj_sel == ADJ_HOUR));

  mod_counter #(.WIDTH(SEC_BIT), .MOD(SEC_MOD)) u_sec (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (i_clear),
    .load     (load_acc),
    .load_val (i_load_sec),
    .inc      (sec_inc),
    .count    (o_sec),
    .wrap     (sec_wrap)
  );

  mod_counter #(.WIDTH(MIN_BIT), .MOD(MIN_MOD)) u_min (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (i_clear),
    .load     (load_acc),
    .load_val (i_load_min),
    .inc      (min_inc),
    .count    (o_min),
    .wrap     (min_wrap)
  );

  mod_counter #(.WIDTH(HOUR_BIT), .MOD(HOUR_MAX)) u_hour (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (i_clear),
    .load     (load_acc),
    .load_val (i_load_hour),
    .inc      (hour_inc),
    .count    (o_hour),
    .wrap     (hour_wrap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_min_tick  <= 1'b0;
      o_hour_tick <= 1'b0;
      o_day_tick  <= 1'b0;
      o_load_err  <= 1'b0;
    end else begin
      o_min_tick  <= run && sec_wrap;
      o_hour_tick <= run && min_wrap;
      o_day_tick  <= run && hour_wrap;
      o_load_err  <= load_bad;
    end
  end

  assign o_adj_mode = (state == ST_ADJ);

endmodule

// File: tb/tb_hms_counter.sv
// Bench for hms_counter: directed scenarios plus random stimulus, checked each
// cycle against a seconds-of-day reference model.
module tb_hms_counter;

  localparam int HMAX = 24;
  localparam int DAY  = HMAX * 3600;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0, clr = 1'b0, ld = 1'b0, adj_en = 1'b0, inc = 1'b0;
  logic [5:0] ls = '0, lm = '0, lh = '0;
  logic [1:0] sel = '0;
  logic [5:0] o_sec, o_min, o_hour;
  logic       o_min_tick, o_hour_tick, o_day_tick, o_adj_mode, o_load_err;

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;
  int m_adj = 0;

  hms_counter #(.SEC_BIT(6), .MIN_BIT(6), .HOUR_BIT(6), .HOUR_MAX(HMAX)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_sec_tick  (tick),
    .i_clear     (clr),
    .i_load      (ld),
    .i_load_sec  (ls),
    .i_load_min  (lm),
    .i_load_hour (lh),
    .i_adj_en    (adj_en),
    .i_adj_sel   (sel),
    .i_adj_inc   (inc),
    .o_sec       (o_sec),
    .o_min       (o_min),
    .o_hour      (o_hour),
    .o_min_tick  (o_min_tick),
    .o_hour_tick (o_hour_tick),
    .o_day_tick  (o_day_tick),
    .o_adj_mode  (o_adj_mode),
    .o_load_err  (o_load_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input int e_mt, input int e_ht, input int e_dt, input int e_err);
    check_eq("sec", 32'(o_sec), t % 60);
    check_eq("min", 32'(o_min), (t / 60) % 60);
    check_eq("hour", 32'(o_hour), t / 3600);
    check_eq("min_tick", 32'(o_min_tick), e_mt);
    check_eq("hour_tick", 32'(o_hour_tick), e_ht);
    check_eq("day_tick", 32'(o_day_tick), e_dt);
    check_eq("load_err", 32'(o_load_err), e_err);
    check_eq("adj_mode", 32'(o_adj_mode), m_adj);
  endtask

  // Advance the model by the current inputs, clock the DUT, compare, drop pulses.
  task automatic cycle();
    int e_mt = 0, e_ht = 0, e_dt = 0, e_err = 0;
    int h, m, s;
    if (clr) begin
      t = 0;
    end else if (ld) begin
      if (int'(ls) < 60 && int'(lm) < 60 && int'(lh) < HMAX) t = int'(lh) * 3600 + int'(lm) * 60 + int'(ls);
      else e_err = 1;
    end else if (m_adj == 0 && tick) begin
      t = (t + 1) % DAY;
      e_mt = (t % 60 == 0) ? 1 : 0;
      e_ht = (t % 3600 == 0) ? 1 : 0;
      e_dt = (t == 0) ? 1 : 0;
    end else if (m_adj == 1 && inc) begin
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      case (sel)
        2'd0:    s = (s + 1) % 60;
        2'd1:    m = (m + 1) % 60;
        2'd2:    h = (h + 1) % HMAX;
        default: ;
      endcase
      t = h * 3600 + m * 60 + s;
    end
    m_adj = adj_en ? 1 : 0;
    @(posedge clk);
    #1;
    check_outputs(e_mt, e_ht, e_dt, e_err);
    tick = 1'b0;
    clr  = 1'b0;
    ld   = 1'b0;
    inc  = 1'b0;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    ld = 1'b1;
    lh = 6'(h);
    lm = 6'(m);
    ls = 6'(s);
    cycle();
  endtask

  initial begin
    #12;
    check_outputs(0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 60; i++) begin
      tick = 1'b1;
      cycle();
    end
    cycle();

    do_load(23, 59, 59);
    tick = 1'b1;
    cycle();
    cycle();

    do_load(5, 6, 7);
    do_load(24, 10, 5);
    cycle();

    do_load(0, 59, 30);
    adj_en = 1'b1;
    cycle();
    sel = 2'd1;
    inc = 1'b1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      cycle();
    end
    sel = 2'd3;
    inc = 1'b1;
    cycle();
    sel = 2'd2;
    do_load(23, 59, 59);
    inc = 1'b1;
    cycle();
    adj_en = 1'b0;
    cycle();

    adj_en = 1'b1;
    tick   = 1'b1;
    cycle();
    adj_en = 1'b0;
    cycle();

    do_load(0, 0, 59);
    tick = 1'b1;
    clr  = 1'b1;
    cycle();
    do_load(1, 2, 59);
    tick = 1'b1;
    ld   = 1'b1;
    lh   = 6'd30;
    cycle();

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) adj_en = ~adj_en;
      sel  = 2'($urandom_range(0, 3));
      tick = ($urandom_range(0, 2) == 0);
      inc  = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 24) == 0) begin
        ld = 1'b1;
        lh = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) :
             6'($urandom_range(HMAX - 2, HMAX - 1));
        lm = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(57, 59));
        ls = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(50, 59));
      end
      cycle();
    end
    adj_en = 1'b0;
    cycle();

    do_load(12, 34, 56);
    adj_en = 1'b1;
    cycle();
    #2;
    reset_n = 1'b0;
    #1;
    t = 0;
    m_adj = 0;
    check_outputs(0, 0, 0, 0);
    adj_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    tick = 1'b1;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
